// File: rtl/mul_issue_arbiter_if.sv
// Bundle of every handshake and data signal around the multiplier issue arbiter.
// slave: the arbiter's view; master: the surrounding requesters/multiplier view.
// p_uop_bits is the width of the rv_uop micro-op encoding carried alongside each request.
interface mul_issue_arbiter_if #(
    parameter int p_seq_num_bits = 8,
    parameter int p_max_inflight = 4,
    parameter int p_uop_bits     = 8
);
    logic                        req0_val, req0_rdy;
    logic [31:0]                 req0_pc, req0_op1, req0_op2;
    logic [p_seq_num_bits-1:0]   req0_seq_num;
    logic [4:0]                  req0_waddr;
    logic [p_uop_bits-1:0]       req0_uop;

    logic                        req1_val, req1_rdy;
    logic [31:0]                 req1_pc, req1_op1, req1_op2;
    logic [p_seq_num_bits-1:0]   req1_seq_num;
    logic [4:0]                  req1_waddr;
    logic [p_uop_bits-1:0]       req1_uop;

    logic                        mul_val, mul_rdy;
    logic [31:0]                 mul_pc, mul_op1, mul_op2;
    logic [p_seq_num_bits-1:0]   mul_seq_num;
    logic [4:0]                  mul_waddr;
    logic [p_uop_bits-1:0]       mul_uop;

    logic                        res_val, res_rdy;
    logic [31:0]                 res_pc, res_wdata;
    logic [p_seq_num_bits-1:0]   res_seq_num;
    logic [4:0]                  res_waddr;
    logic                        res_wen;

    logic                        rsp0_val, rsp0_rdy;
    logic [31:0]                 rsp0_pc, rsp0_wdata;
    logic [p_seq_num_bits-1:0]   rsp0_seq_num;
    logic [4:0]                  rsp0_waddr;
    logic                        rsp0_wen;

    logic                        rsp1_val, rsp1_rdy;
    logic [31:0]                 rsp1_pc, rsp1_wdata;
    logic [p_seq_num_bits-1:0]   rsp1_seq_num;
    logic [4:0]                  rsp1_waddr;
    logic                        rsp1_wen;

    logic [$clog2(p_max_inflight):0] inflight;
    logic                        err;

    modport slave (
        input  req0_val, req0_pc, req0_op1, req0_op2, req0_seq_num, req0_waddr, req0_uop,
        input  req1_val, req1_pc, req1_op1, req1_op2, req1_seq_num, req1_waddr, req1_uop,
        output req0_rdy, req1_rdy,
        output mul_val, mul_pc, mul_op1, mul_op2, mul_seq_num, mul_waddr, mul_uop,
        input  mul_rdy,
        input  res_val, res_pc, res_seq_num, res_waddr, res_wdata, res_wen,
        output res_rdy,
        output rsp0_val, rsp0_pc, rsp0_seq_num, rsp0_waddr, rsp0_wdata, rsp0_wen,
        output rsp1_val, rsp1_pc, rsp1_seq_num, rsp1_waddr, rsp1_wdata, rsp1_wen,
        input  rsp0_rdy, rsp1_rdy,
        output inflight, err
    );

    modport master (
        output req0_val, req0_pc, req0_op1, req0_op2, req0_seq_num, req0_waddr, req0_uop,
        output req1_val, req1_pc, req1_op1, req1_op2, req1_seq_num, req1_waddr, req1_uop,
        input  req0_rdy, req1_rdy,
        input  mul_val, mul_pc, mul_op1, mul_op2, mul_seq_num, mul_waddr, mul_uop,
        output mul_rdy,
        output res_val, res_pc, res_seq_num, res_waddr, res_wdata, res_wen,
        input  res_rdy,
        input  rsp0_val, rsp0_pc, rsp0_seq_num, rsp0_waddr, rsp0_wdata, rsp0_wen,
        input  rsp1_val, rsp1_pc, rsp1_seq_num, rsp1_waddr, rsp1_wdata, rsp1_wen,
        output rsp0_rdy, rsp1_rdy,
        input  inflight, err
    );
endinterface

// File: rtl/mul_issue_arbiter.sv
// Two-requester arbiter in front of a shared multiplier. Issues are granted
// round-robin on ties; an in-order tag FIFO remembers who issued each
// multiply so that results are steered back to the right requester.
module mul_issue_arbiter #(
    parameter int p_seq_num_bits = 8,
    parameter int p_max_inflight = 4
) (
    input logic               clk,
    input logic               rst,
    mul_issue_arbiter_if.slave bus
);
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

    localparam int c_ptr_bits = $clog2(p_max_inflight);
    localparam int c_cnt_bits = c_ptr_bits + 1;
    localparam logic [c_cnt_bits-1:0] c_full_cnt = c_cnt_bits'(p_max_inflight);

    req_id_e                   r_tags [p_max_inflight];
    logic [c_ptr_bits-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_cnt_bits-1:0]     r_count;
    req_id_e                   r_prio;
    logic                      r_err;

    req_id_e                   w_grant, w_head;
    logic                      w_full, w_empty, w_issue, w_pop;
    logic [p_seq_num_bits-1:0] w_mul_seq_num;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    assign w_head  = r_tags[r_rd_ptr];
    assign w_issue = bus.mul_val & bus.mul_rdy;
    assign w_pop   = bus.res_val & bus.res_rdy;

    assign bus.inflight = r_count;
    assign bus.err      = r_err;

    // Grant: a lone valid requester wins; on a tie the priority pointer decides.
    always_comb begin
        w_grant = REQ0;
        if (bus.req0_val && bus.req1_val) begin
            w_grant = r_prio;
        end else if (bus.req1_val) begin
            w_grant = REQ1;
        end
    end

    // Issue path: handshake qualification and pass-through of the granted request.
    always_comb begin
        bus.mul_val  = (bus.req0_val | bus.req1_val) & ~w_full & ~rst;
        bus.req0_rdy = (w_grant == REQ0) & bus.mul_rdy & ~w_full & ~rst;
        bus.req1_rdy = (w_grant == REQ1) & bus.mul_rdy & ~w_full & ~rst;
        bus.mul_pc   = bus.req0_pc;
        bus.mul_op1  = bus.req0_op1;
        bus.mul_op2  = bus.req0_op2;
        w_mul_seq_num = bus.req0_seq_num;
        bus.mul_waddr = bus.req0_waddr;
        bus.mul_uop  = bus.req0_uop;
        if (w_grant == REQ1) begin
            bus.mul_pc    = bus.req1_pc;
            bus.mul_op1   = bus.req1_op1;
            bus.mul_op2   = bus.req1_op2;
            w_mul_seq_num = bus.req1_seq_num;
            bus.mul_waddr = bus.req1_waddr;
            bus.mul_uop   = bus.req1_uop;
        end
        bus.mul_seq_num = w_mul_seq_num;
    end

    // Result path: the FIFO head owner receives the result; fields fan out to both.
    always_comb begin
        bus.rsp0_val = bus.res_val & ~w_empty & (w_head == REQ0) & ~rst;
        bus.rsp1_val = bus.res_val & ~w_empty & (w_head == REQ1) & ~rst;
        bus.res_rdy  = ~w_empty & ~rst &
                       ((w_head == REQ0) ? bus.rsp0_rdy : bus.rsp1_rdy);
        bus.rsp0_pc      = bus.res_pc;
        bus.rsp0_seq_num = bus.res_seq_num;
        bus.rsp0_waddr   = bus.res_waddr;
        bus.rsp0_wdata   = bus.res_wdata;
        bus.rsp0_wen     = bus.res_wen;
        bus.rsp1_pc      = bus.res_pc;
        bus.rsp1_seq_num = bus.res_seq_num;
        bus.rsp1_waddr   = bus.res_waddr;
        bus.rsp1_wdata   = bus.res_wdata;
        bus.rsp1_wen     = bus.res_wen;
    end

    // Tag storage: record the issuing requester at the write pointer.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tags[r_wr_ptr] <= w_grant;
        end
    end

    // Control state: FIFO pointers/count, round-robin pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_prio   <= REQ0;
            r_err    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_bits'(1);
                r_prio   <= (w_grant == REQ0) ? REQ1 : REQ0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_bits'(1);
            end
            if (w_issue && !w_pop) begin
                r_count <= r_count + c_cnt_bits'(1);
            end else if (!w_issue && w_pop) begin
                r_count <= r_count - c_cnt_bits'(1);
            end
            if (bus.res_val && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Self-checking bench for mul_issue_arbiter: directed vector table, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_mul_issue_arbiter;
    localparam int SEQ  = 8;
    localparam int MAXI = 4;
    localparam int UOP  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_issue_arbiter_if #(.p_seq_num_bits(SEQ), .p_max_inflight(MAXI), .p_uop_bits(UOP)) bus ();

    mul_issue_arbiter #(.p_seq_num_bits(SEQ), .p_max_inflight(MAXI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: owner ids of in-flight multiplies, oldest first.
    int q[$];
    int prio;
    bit err_m;

    typedef struct {
        logic [5:0] in;    // {req0_val, req1_val, mul_rdy, res_val, rsp0_rdy, rsp1_rdy}
        logic [5:0] exp;   // {mul_val, req0_rdy, req1_rdy, res_rdy, rsp0_val, rsp1_val}
        int         infl;
        bit         err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rand_data();
        bus.req0_pc = $urandom; bus.req0_op1 = $urandom; bus.req0_op2 = $urandom;
        bus.req0_seq_num = SEQ'($urandom); bus.req0_waddr = 5'($urandom); bus.req0_uop = UOP'($urandom);
        bus.req1_pc = $urandom; bus.req1_op1 = $urandom; bus.req1_op2 = $urandom;
        bus.req1_seq_num = SEQ'($urandom); bus.req1_waddr = 5'($urandom); bus.req1_uop = UOP'($urandom);
        bus.res_pc = $urandom; bus.res_wdata = $urandom; bus.res_seq_num = SEQ'($urandom);
        bus.res_waddr = 5'($urandom); bus.res_wen = 1'($urandom);
    endtask

    task automatic set_ctl(logic [5:0] v);
        {bus.req0_val, bus.req1_val, bus.mul_rdy, bus.res_val, bus.rsp0_rdy, bus.rsp1_rdy} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock: compare DUT against the model for the applied inputs, then advance the model.
    task automatic cycle();
        int g;
        int head;
        bit full, empty, e_mval, e_rrdy, issue, pop;
        #1;
        if (rst) begin
            chk("rst_mul_val", bus.mul_val, 0);
            chk("rst_req0_rdy", bus.req0_rdy, 0);
            chk("rst_req1_rdy", bus.req1_rdy, 0);
            chk("rst_res_rdy", bus.res_rdy, 0);
            chk("rst_rsp0_val", bus.rsp0_val, 0);
            chk("rst_rsp1_val", bus.rsp1_val, 0);
            @(posedge clk);
            q.delete();
            prio = 0;
            err_m = 1'b0;
            @(negedge clk);
            return;
        end
        full  = (q.size() == MAXI);
        empty = (q.size() == 0);
        g = (bus.req0_val && bus.req1_val) ? prio : (bus.req1_val ? 1 : 0);
        head = empty ? 0 : q[0];
        e_mval = (bus.req0_val || bus.req1_val) && !full;
        e_rrdy = !empty && ((head == 0) ? bus.rsp0_rdy : bus.rsp1_rdy);
        chk("inflight", bus.inflight, q.size());
        chk("err", bus.err, err_m);
        chk("mul_val", bus.mul_val, e_mval);
        chk("req0_rdy", bus.req0_rdy, (g == 0) && bus.mul_rdy && !full);
        chk("req1_rdy", bus.req1_rdy, (g == 1) && bus.mul_rdy && !full);
        chk("res_rdy", bus.res_rdy, e_rrdy);
        chk("rsp0_val", bus.rsp0_val, bus.res_val && !empty && head == 0);
        chk("rsp1_val", bus.rsp1_val, bus.res_val && !empty && head == 1);
        if (e_mval) begin
            chk("mul_op1", bus.mul_op1, (g == 1) ? bus.req1_op1 : bus.req0_op1);
            chk("mul_op2", bus.mul_op2, (g == 1) ? bus.req1_op2 : bus.req0_op2);
            chk("mul_seq_num", bus.mul_seq_num, (g == 1) ? bus.req1_seq_num : bus.req0_seq_num);
            chk("mul_uop", bus.mul_uop, (g == 1) ? bus.req1_uop : bus.req0_uop);
        end
        chk("rsp0_wdata", bus.rsp0_wdata, bus.res_wdata);
        chk("rsp1_seq_num", bus.rsp1_seq_num, bus.res_seq_num);
        issue = e_mval && bus.mul_rdy;
        pop   = bus.res_val && e_rrdy;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (issue) begin
            q.push_back(g);
            prio = 1 - g;
        end
        if (bus.res_val && empty) err_m = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{6'b111000, 6'b110000, 0, 1'b0};
        tbl[1]  = '{6'b111000, 6'b101000, 1, 1'b0};
        tbl[2]  = '{6'b111000, 6'b110000, 2, 1'b0};
        tbl[3]  = '{6'b111000, 6'b101000, 3, 1'b0};
        tbl[4]  = '{6'b111110, 6'b000110, 4, 1'b0};
        tbl[5]  = '{6'b101100, 6'b110001, 3, 1'b0};
        tbl[6]  = '{6'b001101, 6'b000101, 4, 1'b0};
        tbl[7]  = '{6'b000111, 6'b000110, 3, 1'b0};
        tbl[8]  = '{6'b000111, 6'b000101, 2, 1'b0};
        tbl[9]  = '{6'b000111, 6'b000110, 1, 1'b0};
        tbl[10] = '{6'b000111, 6'b000000, 0, 1'b0};
        tbl[11] = '{6'b000000, 6'b000000, 0, 1'b1};

        rand_data();
        set_ctl(6'b111111);
        rst = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Directed vector table from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            set_ctl(tbl[i].in);
            #1;
            chk($sformatf("tbl%0d_ctl", i),
                {bus.mul_val, bus.req0_rdy, bus.req1_rdy, bus.res_rdy, bus.rsp0_val, bus.rsp1_val},
                tbl[i].exp);
            chk($sformatf("tbl%0d_inflight", i), bus.inflight, tbl[i].infl);
            chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].err);
            tick();
        end

        // Results come back to the requester that issued them, in issue order.
        rst = 1'b1; set_ctl(6'b000000); cycle(); rst = 1'b0;
        set_ctl(6'b011000); cycle();
        set_ctl(6'b101000); cycle();
        set_ctl(6'b000111); bus.res_wdata = 32'h12; #1;
        chk("order_rsp1_val", bus.rsp1_val, 1);
        chk("order_rsp1_wdata", bus.rsp1_wdata, 32'h12);
        chk("order_rsp0_quiet", bus.rsp0_val, 0);
        cycle();
        bus.res_wdata = 32'h34; #1;
        chk("order_rsp0_val", bus.rsp0_val, 1);
        chk("order_rsp0_wdata", bus.rsp0_wdata, 32'h34);
        cycle();
        set_ctl(6'b000000); #1;
        chk("order_inflight_zero", bus.inflight, 0);
        cycle();

        // Reset mid-operation discards tags and restores req0 priority.
        set_ctl(6'b101000); cycle(); cycle(); cycle();
        set_ctl(6'b000000); #1;
        chk("midrst_inflight3", bus.inflight, 3);
        rst = 1'b1; set_ctl(6'b111100); cycle(); rst = 1'b0;
        set_ctl(6'b111000); #1;
        chk("midrst_inflight0", bus.inflight, 0);
        chk("midrst_err0", bus.err, 0);
        chk("midrst_req0_wins", bus.req0_rdy, 1);
        chk("midrst_req1_waits", bus.req1_rdy, 0);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rand_data();
            rst = ($urandom_range(0, 99) == 0);
            bus.req0_val = ($urandom_range(0, 99) < 55);
            bus.req1_val = ($urandom_range(0, 99) < 55);
            bus.mul_rdy  = ($urandom_range(0, 99) < 70);
            bus.res_val  = (q.size() != 0) ? ($urandom_range(0, 99) < 60)
                                           : ($urandom_range(0, 99) < 3);
            bus.rsp0_rdy = ($urandom_range(0, 99) < 70);
            bus.rsp1_rdy = ($urandom_range(0, 99) < 70);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_issue_arbiter.md
MUL_ISSUE_ARBITER -- requirements
Module: mul_issue_arbiter

Interface
REQ-001 SHALL have parameter p_seq_num_bits, default 8, sequence-number width.
REQ-002 SHALL have parameter p_max_inflight, default 4 (power of 2, >=2), max issued-but-unreturned multiplies.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 reqN_val / reqN_rdy (N=0,1)  in/out  1/1  requester N issue handshake.
REQ-006 reqN_pc, reqN_op1, reqN_op2  in  32 each  requester N operands.
REQ-007 reqN_seq_num / reqN_waddr / reqN_uop  in  p_seq_num_bits / 5 / rv_uop  requester N tags.
REQ-008 mul_val / mul_rdy  out/in  1/1  issue handshake to shared multiplier D side.
REQ-009 mul_pc, mul_seq_num, mul_op1, mul_op2, mul_waddr, mul_uop  out  as req fields  granted request.
REQ-010 res_val / res_rdy  in/out  1/1  result handshake from multiplier W side.
REQ-011 res_pc, res_seq_num, res_waddr, res_wdata, res_wen  in  32/p_seq_num_bits/5/32/1  result fields.
REQ-012 rspN_val / rspN_rdy  out/in  1/1  result handshake to requester N.
REQ-013 rspN_pc, rspN_seq_num, rspN_waddr, rspN_wdata, rspN_wen  out  as res fields  result to requester N.
REQ-014 inflight  out  $clog2(p_max_inflight)+1  current in-flight count.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Transfer on any port SHALL occur when val & rdy are high in the same cycle.
REQ-017 Grant SHALL be combinational: only one reqN valid -> that one; both valid -> requester named by priority pointer.
REQ-018 Priority pointer SHALL move to the non-granted requester after each issue transfer; otherwise unchanged.
REQ-019 mul_val SHALL equal (req0_val | req1_val) & !full; mul_* fields SHALL mux from granted requester (don't-care when mul_val low).
REQ-020 reqN_rdy SHALL be high only when N is granted, mul_rdy high, FIFO not full; non-granted rdy low.
REQ-021 Each issue transfer SHALL push the granted requester id into an in-order tag FIFO of depth p_max_inflight.
REQ-022 Full (count==p_max_inflight) SHALL block issue even if a result pops that cycle.
REQ-023 Head id H SHALL route results: rspH_val = res_val & !empty; other rsp val low; both rsp fields copy res fields.
REQ-024 res_rdy SHALL equal rspH_rdy & !empty; each result transfer pops one FIFO entry.
REQ-025 Push and pop in same cycle SHALL leave count unchanged and store the new id correctly, incl. pointer wrap-around.
REQ-026 Both paths SHALL be zero-latency combinational pass-through; no data registering.
REQ-027 res_val while empty SHALL set err (sticky), keep res_rdy low, no pop, no rsp valid.
REQ-028 inflight SHALL equal FIFO count, updated the cycle after each push/pop.

Reset
REQ-029 While rst is high: mul_val, reqN_rdy, res_rdy, rspN_val SHALL be 0.
REQ-030 After rst: FIFO empty, inflight=0, priority pointer=requester 0, err=0; rst mid-operation SHALL discard all in-flight tags.

Verification
REQ-031 Both requesters valid, mul_rdy=1, 4 cycles -> grants 0,1,0,1; inflight 1..4 by cycle 4.
REQ-032 p_max_inflight=4 full, req0_val=1, res transfer same cycle -> no issue that cycle; issue next cycle, inflight stays 4.
REQ-033 Issue req1 then req0; results wdata 0x12, 0x34 -> rsp1 gets 0x12, then rsp0 gets 0x34; inflight back to 0.
REQ-034 Head owner rsp1_rdy=0 with res_val=1 -> res_rdy=0, rsp0_val=0, no pop until rsp1_rdy=1.
REQ-035 res_val=1 with inflight=0 -> err=1 next cycle, stays 1 until rst.
REQ-036 rst asserted with inflight=3 -> next cycle inflight=0, err=0, req0 wins first tie.
